decode: RTL and testbench
=========================

# decode

Instruction decode and sequencing stage of the CPU, directly downstream of `fetch`. It takes each completed 16-bit instruction word from `fetch` and decodes it into control fields for the execute stage. It hands those fields over with a valid/ready handshake. It also drives `fetch_operation` so that `fetch` advances, jumps, returns or restarts the PC.

## Interface
Parameters: none.
- clk  in  1  clock; all state changes on rising edge
- rst_async  in  1  reset, asynchronous, active-high
- fetch_complete  in  1  `fetch` has a new instruction on `inst`
- inst  in  16  instruction word from `fetch`
- fetch_operation  out  fetch_operation_t  one-cycle command to `fetch`; `FETCH_NONE` otherwise
- flag_z, flag_c  in  1 each  execute-stage flags, used by conditional jumps
- exec_valid  out  1  decoded fields below are valid
- exec_ready  in  1  execute accepts the fields
- alu_op  out  4  ALU operation
- rd, rs  out  3 each  destination and source register indices
- imm  out  8  immediate value
- use_imm  out  1  ALU B operand is `imm` instead of `rs`
- reg_we  out  1  write the result to `rd`
- mem_read, mem_write  out  1 each  data memory access at address r6:r7
- illegal_inst  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  the decoder is in HALT

## Operation
- Opcode is `inst[15:12]`.
  - 0x0: NOP, or HALT when `inst[11:0]`=0xFFF.
  - 0x1: ALU register-register. rd=[11:9], rs=[8:6], alu_op=[3:0], reg_we.
  - 0x2: LDI. rd=[11:9], imm=[7:0], alu_op=ALU_PASS_B, use_imm, reg_we.
  - 0x3: ADDI. Same fields as LDI, with alu_op=ALU_ADD.
  - 0x4: LOAD. rd=[11:9], mem_read, reg_we.
  - 0x5: STORE. rs=[8:6], mem_write.
  - 0x6: JMP. `FETCH_JUMP_R01`.
  - 0x7: JCC. Condition is [1:0]: 00=Z, 01=NZ, 10=C, 11=NC. Taken gives `FETCH_JUMP_R67`; not taken gives `FETCH_INC`.
  - 0x8: RET. `FETCH_RET`.
  - 0x9–0xF: illegal. Treated as NOP and pulses `illegal_inst`.
- Opcodes 0x1–0x5 are exec-class and go through ISSUE. All others complete inside the decoder.
- Instruction register `ir` is loaded from `inst` on the accepting `fetch_complete` edge.
- State machine:
  - BOOT → WAIT: sets `fetch_operation`=`FETCH_RESTART`.
  - WAIT → DECODE: when `fetch_complete`=1 and `fetch_operation`=`FETCH_NONE`; loads `ir`.
  - DECODE → ISSUE: exec-class instruction; registers all fields and sets `exec_valid`.
  - DECODE → WAIT: non-exec instruction; sets `fetch_operation` per opcode (NOP/illegal = `FETCH_INC`).
  - DECODE → HALT: HALT instruction.
  - ISSUE → WAIT: on the edge where `exec_valid`&`exec_ready`; clears `exec_valid` and sets `FETCH_INC`.
  - HALT: terminal until reset; `halted`=1.
- Fields are stable while `exec_valid`=1. Fields are don't-care, but driven to 0, when `exec_valid`=0.

## Timing
- Reset values: state BOOT, `fetch_operation`=`FETCH_NONE`, `exec_valid`=0, all field outputs 0, `illegal_inst`=0, `halted`=0, `ir`=0.
- All outputs are registered. `fetch_operation` and `illegal_inst` are high for exactly one cycle, namely the first cycle of WAIT.
- `fetch_complete` is ignored during that first WAIT cycle and in every state other than WAIT.
- Latency from an accepted `fetch_complete` edge:
  - `exec_valid` rises 2 edges later.
  - For a non-exec instruction, `fetch_operation` is asserted 2 edges later.
- Execute updates `flag_z` and `flag_c` no later than its handshake edge. The decoder samples the flags on the DECODE→WAIT edge.
- If `exec_ready` is held low, ISSUE holds indefinitely with no output change.
- Asserting reset in any state forces BOOT immediately. `exec_valid` drops asynchronously and the in-flight instruction is discarded.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_operation_t` with values NONE, INC, RESTART, JUMP_R01, JUMP_R67, RET.
  - Opcode constants.
  - ALU op constants: ALU_ADD=4'h0, ALU_PASS_B=4'hF.
  - The state enum.
- Natural sub-module: `inst_field_decode`, a combinational map from `ir`, `flag_z` and `flag_c` to fields, exec-class flag and fetch command. The FSM and registers stay in `decode`.

## Test plan
- Reset release: one cycle later `fetch_operation`=RESTART for one cycle, then NONE. `exec_valid`=0 throughout.
- `inst`=0x1A45 with `exec_ready` held low for 3 cycles:
  - `exec_valid` holds for 3 cycles with rd=5, rs=1, alu_op=5, reg_we=1.
  - On the handshake edge, `exec_valid` drops and the next cycle has `fetch_operation`=INC.
- `inst`=0x7001 with `flag_z`=0: `fetch_operation`=JUMP_R67 and `exec_valid` never rises. Repeat with `flag_z`=1: `fetch_operation`=INC.
- `inst`=0xB123: `illegal_inst` pulses for one cycle together with `fetch_operation`=INC.
- `inst`=0x0FFF: `halted`=1, and further `fetch_complete` pulses produce no output change until reset.
- Reset asserted mid-ISSUE: `exec_valid` is 0 immediately, and the boot sequence repeats.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch commands, opcodes, ALU op codes, decoder
// state encoding and the decoded execute-field bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_NONE     = 3'd0,
        FETCH_INC      = 3'd1,
        FETCH_RESTART  = 3'd2,
        FETCH_JUMP_R01 = 3'd3,
        FETCH_JUMP_R67 = 3'd4,
        FETCH_RET      = 3'd5
    } fetch_operation_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_LDI   = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JCC   = 4'h7;
    localparam logic [3:0] OP_RET   = 4'h8;

    localparam logic [11:0] HALT_PATTERN = 12'hFFF;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_PASS_B = 4'hF;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } decode_state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        logic       use_imm;
        logic       reg_we;
        logic       mem_read;
        logic       mem_write;
    } exec_fields_t;

    // Condition code in inst[1:0]: 00=Z, 01=NZ, 10=C, 11=NC.
    function automatic logic jcc_taken(input logic [1:0] cond,
                                       input logic flag_z,
                                       input logic flag_c);
        logic taken;
        case (cond)
            2'b00:   taken = flag_z;
            2'b01:   taken = ~flag_z;
            2'b10:   taken = flag_c;
            default: taken = ~flag_c;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational map from the instruction register and execute flags to
// execute fields, instruction class and the fetch command.
module inst_field_decode
    import cpu_pkg::*;
(
    input  logic [15:0]      ir_i,
    input  logic             flag_z_i,
    input  logic             flag_c_i,
    output exec_fields_t     fields_o,
    output logic             is_exec_o,
    output logic             is_halt_o,
    output logic             is_illegal_o,
    output fetch_operation_t fetch_op_o
);

    logic [3:0] opcode;

    assign opcode = ir_i[15:12];

    always_comb begin
        fields_o     = '0;
        is_exec_o    = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        fetch_op_o   = FETCH_INC;

        case (opcode)
            OP_NOP: begin
                is_halt_o = (ir_i[11:0] == HALT_PATTERN);
            end
            OP_ALU: begin
                is_exec_o       = 1'b1;
                fields_o.rd     = ir_i[11:9];
                fields_o.rs     = ir_i[8:6];
                fields_o.alu_op = ir_i[3:0];
                fields_o.reg_we = 1'b1;
            end
            OP_LDI, OP_ADDI: begin
                is_exec_o        = 1'b1;
                fields_o.rd      = ir_i[11:9];
                fields_o.imm     = ir_i[7:0];
                fields_o.alu_op  = (opcode == OP_LDI) ? ALU_PASS_B : ALU_ADD;
                fields_o.use_imm = 1'b1;
                fields_o.reg_we  = 1'b1;
            end
            OP_LOAD: begin
                is_exec_o         = 1'b1;
                fields_o.rd       = ir_i[11:9];
                fields_o.mem_read = 1'b1;
                fields_o.reg_we   = 1'b1;
            end
            OP_STORE: begin
                is_exec_o          = 1'b1;
                fields_o.rs        = ir_i[8:6];
                fields_o.mem_write = 1'b1;
            end
            OP_JMP: begin
                fetch_op_o = FETCH_JUMP_R01;
            end
            OP_JCC: begin
                fetch_op_o = jcc_taken(ir_i[1:0], flag_z_i, flag_c_i)
                             ? FETCH_JUMP_R67 : FETCH_INC;
            end
            OP_RET: begin
                fetch_op_o = FETCH_RET;
            end
            default: begin
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode.sv
// Instruction decode/sequencing stage: latches instructions from fetch, hands
// exec-class fields to execute over valid/ready and steers the fetch PC.
module decode
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_async,
    input  logic             fetch_complete,
    input  logic [15:0]      inst,
    output fetch_operation_t fetch_operation,
    input  logic             flag_z,
    input  logic             flag_c,
    output logic             exec_valid,
    input  logic             exec_ready,
    output logic [3:0]       alu_op,
    output logic [2:0]       rd,
    output logic [2:0]       rs,
    output logic [7:0]       imm,
    output logic             use_imm,
    output logic             reg_we,
    output logic             mem_read,
    output logic             mem_write,
    output logic             illegal_inst,
    output logic             halted
);

    decode_state_t    state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    fetch_operation_t fetch_op_q, fetch_op_d;
    logic             exec_valid_q, exec_valid_d;
    exec_fields_t     fields_q, fields_d;
    logic             illegal_q, illegal_d;
    logic             halted_q, halted_d;

    exec_fields_t     dec_fields;
    logic             dec_is_exec;
    logic             dec_is_halt;
    logic             dec_is_illegal;
    fetch_operation_t dec_fetch_op;

    inst_field_decode u_field_decode (
        .ir_i         (ir_q),
        .flag_z_i     (flag_z),
        .flag_c_i     (flag_c),
        .fields_o     (dec_fields),
        .is_exec_o    (dec_is_exec),
        .is_halt_o    (dec_is_halt),
        .is_illegal_o (dec_is_illegal),
        .fetch_op_o   (dec_fetch_op)
    );

    // fetch_op_q is non-NONE only in the first WAIT cycle, which is also the
    // cycle in which fetch_complete must be ignored.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        fetch_op_d   = FETCH_NONE;
        exec_valid_d = exec_valid_q;
        fields_d     = fields_q;
        illegal_d    = 1'b0;
        halted_d     = halted_q;

        case (state_q)
            ST_BOOT: begin
                fetch_op_d = FETCH_RESTART;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch_complete && (fetch_op_q == FETCH_NONE)) begin
                    ir_d    = inst;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_is_halt) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (dec_is_exec) begin
                    exec_valid_d = 1'b1;
                    fields_d     = dec_fields;
                    state_d      = ST_ISSUE;
                end else begin
                    fetch_op_d = dec_fetch_op;
                    illegal_d  = dec_is_illegal;
                    state_d    = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (exec_valid_q && exec_ready) begin
                    exec_valid_d = 1'b0;
                    fields_d     = '0;
                    fetch_op_d   = FETCH_INC;
                    state_d      = ST_WAIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q      <= ST_BOOT;
            ir_q         <= '0;
            fetch_op_q   <= FETCH_NONE;
            exec_valid_q <= 1'b0;
            fields_q     <= '0;
            illegal_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            fetch_op_q   <= fetch_op_d;
            exec_valid_q <= exec_valid_d;
            fields_q     <= fields_d;
            illegal_q    <= illegal_d;
            halted_q     <= halted_d;
        end
    end

    assign fetch_operation = fetch_op_q;
    assign exec_valid      = exec_valid_q;
    assign alu_op          = fields_q.alu_op;
    assign rd              = fields_q.rd;
    assign rs              = fields_q.rs;
    assign imm             = fields_q.imm;
    assign use_imm         = fields_q.use_imm;
    assign reg_we          = fields_q.reg_we;
    assign mem_read        = fields_q.mem_read;
    assign mem_write       = fields_q.mem_write;
    assign illegal_inst    = illegal_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: boot, issue handshake, branches, illegal,
// halt and reset during ISSUE.
module tb_decode;
    import cpu_pkg::*;

    logic             clk;
    logic             rst_async;
    logic             fetch_complete;
    logic [15:0]      inst;
    fetch_operation_t fetch_operation;
    logic             flag_z;
    logic             flag_c;
    logic             exec_valid;
    logic             exec_ready;
    logic [3:0]       alu_op;
    logic [2:0]       rd;
    logic [2:0]       rs;
    logic [7:0]       imm;
    logic             use_imm;
    logic             reg_we;
    logic             mem_read;
    logic             mem_write;
    logic             illegal_inst;
    logic             halted;

    int n_checks = 0;
    int n_fail   = 0;

    decode dut (
        .clk             (clk),
        .rst_async       (rst_async),
        .fetch_complete  (fetch_complete),
        .inst            (inst),
        .fetch_operation (fetch_operation),
        .flag_z          (flag_z),
        .flag_c          (flag_c),
        .exec_valid      (exec_valid),
        .exec_ready      (exec_ready),
        .alu_op          (alu_op),
        .rd              (rd),
        .rs              (rs),
        .imm             (imm),
        .use_imm         (use_imm),
        .reg_we          (reg_we),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .illegal_inst    (illegal_inst),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle fetch_complete pulse; afterwards the decoder sits in DECODE.
    task automatic accept(input logic [15:0] w);
        fetch_complete = 1'b1;
        inst           = w;
        tick();
        fetch_complete = 1'b0;
    endtask

    task automatic boot_after_release();
        tick();
        chk("boot_restart", fetch_operation, FETCH_RESTART);
        chk("boot_valid0", exec_valid, 1'b0);
        tick();
        chk("boot_none", fetch_operation, FETCH_NONE);
        chk("boot_valid1", exec_valid, 1'b0);
    endtask

    initial begin
        rst_async      = 1'b1;
        fetch_complete = 1'b0;
        inst           = 16'h0000;
        flag_z         = 1'b0;
        flag_c         = 1'b0;
        exec_ready     = 1'b0;
        tick();
        tick();
        chk("rst_fetch_op", fetch_operation, FETCH_NONE);
        chk("rst_valid", exec_valid, 1'b0);
        chk("rst_fields", {alu_op, rd, rs, imm, use_imm, reg_we, mem_read, mem_write}, 32'h0);
        chk("rst_illegal", illegal_inst, 1'b0);
        chk("rst_halted", halted, 1'b0);

        rst_async = 1'b0;
        boot_after_release();

        // ALU reg-reg with execute stalling for three cycles
        accept(16'h1A45);
        chk("alu_decode_valid", exec_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("alu_valid", exec_valid, 1'b1);
            chk("alu_rd", rd, 3'd5);
            chk("alu_rs", rs, 3'd1);
            chk("alu_op", alu_op, 4'd5);
            chk("alu_we", reg_we, 1'b1);
            chk("alu_fop", fetch_operation, FETCH_NONE);
        end
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        chk("alu_hs_valid", exec_valid, 1'b0);
        chk("alu_hs_inc", fetch_operation, FETCH_INC);
        chk("alu_hs_rd_zero", rd, 3'd0);

        // fetch_complete in the first WAIT cycle must be ignored
        fetch_complete = 1'b1;
        inst           = 16'hB123;
        tick();
        fetch_complete = 1'b0;
        chk("ign_fop_none", fetch_operation, FETCH_NONE);
        tick();
        chk("ign_no_illegal", illegal_inst, 1'b0);
        chk("ign_fop_still_none", fetch_operation, FETCH_NONE);

        // JCC NZ, Z=0 -> taken
        flag_z = 1'b0;
        accept(16'h7001);
        tick();
        chk("jnz_taken", fetch_operation, FETCH_JUMP_R67);
        chk("jnz_taken_valid", exec_valid, 1'b0);
        tick();
        chk("jnz_after_none", fetch_operation, FETCH_NONE);
        chk("jnz_after_valid", exec_valid, 1'b0);

        // JCC NZ, Z=1 -> not taken
        flag_z = 1'b1;
        accept(16'h7001);
        tick();
        chk("jnz_not_taken", fetch_operation, FETCH_INC);
        chk("jnz_nt_valid", exec_valid, 1'b0);
        tick();

        // JCC C, C=1 -> taken
        flag_c = 1'b1;
        accept(16'h7002);
        tick();
        chk("jc_taken", fetch_operation, FETCH_JUMP_R67);
        tick();

        accept(16'h6000);
        tick();
        chk("jmp", fetch_operation, FETCH_JUMP_R01);
        tick();

        accept(16'h8000);
        tick();
        chk("ret", fetch_operation, FETCH_RET);
        tick();

        // LDI r5, 0x7F with execute ready
        exec_ready = 1'b1;
        accept(16'h2A7F);
        tick();
        chk("ldi_valid", exec_valid, 1'b1);
        chk("ldi_rd", rd, 3'd5);
        chk("ldi_imm", imm, 8'h7F);
        chk("ldi_alu", alu_op, ALU_PASS_B);
        chk("ldi_flags", {use_imm, reg_we, mem_read, mem_write}, 4'b1100);
        tick();
        chk("ldi_hs_valid", exec_valid, 1'b0);
        chk("ldi_hs_inc", fetch_operation, FETCH_INC);
        tick();

        // ADDI r2, 0x03
        accept(16'h3403);
        tick();
        chk("addi_alu", alu_op, ALU_ADD);
        chk("addi_rd_imm", {rd, imm}, {3'd2, 8'h03});
        tick();
        tick();

        // STORE from r1
        accept(16'h5040);
        tick();
        chk("st_valid", exec_valid, 1'b1);
        chk("st_rs", rs, 3'd1);
        chk("st_flags", {use_imm, reg_we, mem_read, mem_write}, 4'b0001);
        tick();
        tick();

        // LOAD into r3
        accept(16'h4600);
        tick();
        chk("ld_rd", rd, 3'd3);
        chk("ld_flags", {use_imm, reg_we, mem_read, mem_write}, 4'b0110);
        tick();
        exec_ready = 1'b0;
        tick();

        // Illegal opcode
        accept(16'hB123);
        chk("ill_pre", illegal_inst, 1'b0);
        tick();
        chk("ill_pulse", illegal_inst, 1'b1);
        chk("ill_inc", fetch_operation, FETCH_INC);
        chk("ill_valid", exec_valid, 1'b0);
        tick();
        chk("ill_gone", illegal_inst, 1'b0);

        // HALT then further fetch_complete pulses have no effect
        accept(16'h0FFF);
        tick();
        chk("halt_set", halted, 1'b1);
        chk("halt_fop", fetch_operation, FETCH_NONE);
        exec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept(16'h1A45);
            tick();
            chk("halt_hold", halted, 1'b1);
            chk("halt_no_valid", exec_valid, 1'b0);
            chk("halt_no_fop", fetch_operation, FETCH_NONE);
        end
        exec_ready = 1'b0;

        // Reset from HALT, then reset asserted mid-ISSUE
        rst_async = 1'b1;
        #2;
        chk("halt_rst", halted, 1'b0);
        tick();
        rst_async = 1'b0;
        boot_after_release();
        accept(16'h1A45);
        tick();
        chk("mid_issue_valid", exec_valid, 1'b1);
        #2;
        rst_async = 1'b1;
        #1;
        chk("async_rst_valid", exec_valid, 1'b0);
        chk("async_rst_rd", rd, 3'd0);
        tick();
        rst_async = 1'b0;
        boot_after_release();
        tick();
        chk("discarded_valid", exec_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
